// File: rtl/tt_um_serial_subtractor_if.sv
// Tiny Tapeout tile bus for the serial subtractor: operand/control inputs, result/status outputs.
interface tt_um_serial_subtractor_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_serial_subtractor.sv
// Multi-cycle borrow-chained subtractor, STEP bits per clock, computing A - B - borrow_in.
// Optional macro SUB_OVF_FLAG_EN adds a registered two's-complement overflow flag on uio_out[4].
module tt_um_serial_subtractor #(
  parameter int unsigned STEP = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  tt_um_serial_subtractor_if.slave        bus
);

  localparam int unsigned NSTEPS = 8 / STEP;
  localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;

  logic [7:0]    a_reg, b_reg;
  logic [7:0]    a_w, b_w, res_w;
  logic [7:0]    res_q;
  logic [CW-1:0] cnt;
  logic          brw, borrow_q;
  logic          ld_a_q, ld_b_q, start_q;
  logic          ld_a_edge, ld_b_edge, start_edge, last_step;
  logic [STEP:0] step_diff;
  logic [7:0]    res_next;
  logic          ovf_bit;
  logic          unused_uio;

  assign unused_uio = &{1'b0, bus.uio_in[7:4]};

  assign ld_a_edge  = bus.uio_in[0] & ~ld_a_q;
  assign ld_b_edge  = bus.uio_in[1] & ~ld_b_q;
  assign start_edge = bus.uio_in[2] & ~start_q;
  assign last_step  = (cnt == LAST);

  // One STEP-wide slice; the extra top bit is the borrow out of the slice.
  assign step_diff = {1'b0, a_w[STEP-1:0]} - {1'b0, b_w[STEP-1:0]} - (STEP+1)'(brw);
  assign res_next  = 8'({step_diff[STEP-1:0], res_w} >> STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (ena) begin
      case (state)
        IDLE, DONE: if (start_edge) state_d = RUN;
        RUN:        if (last_step)  state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      a_w      <= '0;
      b_w      <= '0;
      res_w    <= '0;
      res_q    <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
      borrow_q <= 1'b0;
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      start_q  <= 1'b0;
    end else if (ena) begin
      ld_a_q  <= bus.uio_in[0];
      ld_b_q  <= bus.uio_in[1];
      start_q <= bus.uio_in[2];
      if (state == RUN) begin
        a_w   <= a_w >> STEP;
        b_w   <= b_w >> STEP;
        res_w <= res_next;
        brw   <= step_diff[STEP];
        cnt   <= cnt + CW'(1);
        if (last_step) begin
          res_q    <= res_next;
          borrow_q <= step_diff[STEP];
        end
      end else if (start_edge) begin
        a_w   <= a_reg;
        b_w   <= b_reg;
        brw   <= bus.uio_in[3];
        res_w <= '0;
        cnt   <= '0;
      end else begin
        if (ld_a_edge) a_reg <= bus.ui_in;
        if (ld_b_edge) b_reg <= bus.ui_in;
      end
    end
  end

`ifdef SUB_OVF_FLAG_EN
  logic ovf_q;

  // Operand sign bits come from A_reg/B_reg, which cannot change while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ena && state == RUN && last_step) begin
      ovf_q <= (a_reg[7] ^ b_reg[7]) & (res_next[7] ^ a_reg[7]);
    end
  end

  assign ovf_bit    = ovf_q;
  assign bus.uio_oe = 8'b1111_0000;
`else
  assign ovf_bit    = 1'b0;
  assign bus.uio_oe = 8'b1110_0000;
`endif

  assign bus.uo_out  = res_q;
  assign bus.uio_out = {state == RUN, state == DONE, borrow_q, ovf_bit, 4'b0000};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Bench for tt_um_serial_subtractor: arithmetic reference model plus directed vectors.
module tb_tt_um_serial_subtractor;

  localparam int unsigned LAT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  tt_um_serial_subtractor_if bus ();
  tt_um_serial_subtractor_if bus4 ();

  assign bus4.ui_in  = bus.ui_in;
  assign bus4.uio_in = bus.uio_in;

  tt_um_serial_subtractor #(.STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  tt_um_serial_subtractor #(.STEP(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic, result released after LAT enabled cycles.
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, m_pend_res = '0;
  logic       m_bout = 1'b0, m_pend_bout = 1'b0, m_ovf = 1'b0, m_pend_ovf = 1'b0;
  logic       m_busy = 1'b0, m_done = 1'b0;
  logic [2:0] m_prev = '0, m_edge;
  int         m_left = 0;
  int         m_diff, m_sdiff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_res = '0; m_bout = 1'b0; m_ovf = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_prev = '0; m_left = 0;
    end else if (ena) begin
      m_edge = bus.uio_in[2:0] & ~m_prev;
      m_prev = bus.uio_in[2:0];
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_res  = m_pend_res;
          m_bout = m_pend_bout;
          m_ovf  = m_pend_ovf;
        end
      end else if (m_edge[2]) begin
        m_diff      = int'(m_a) - int'(m_b) - int'(bus.uio_in[3]);
        m_sdiff     = int'($signed(m_a)) - int'($signed(m_b)) - int'(bus.uio_in[3]);
        m_pend_res  = m_diff[7:0];
        m_pend_bout = (m_diff < 0);
        m_pend_ovf  = (m_sdiff < -128) || (m_sdiff > 127);
        m_left      = LAT;
        m_busy      = 1'b1;
        m_done      = 1'b0;
      end else begin
        if (m_edge[0]) m_a = bus.ui_in;
        if (m_edge[1]) m_b = bus.ui_in;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] exp_status, exp_oe;
  always @(negedge clk) begin
`ifdef SUB_OVF_FLAG_EN
    exp_status = {m_busy, m_done, m_bout, m_ovf, 4'h0};
    exp_oe     = 8'hF0;
`else
    exp_status = {m_busy, m_done, m_bout, 1'b0, 4'h0};
    exp_oe     = 8'hE0;
`endif
    check("model uo_out", bus.uo_out, m_res);
    check("model uio_out", bus.uio_out, exp_status);
    check("model uio_oe", bus.uio_oe, exp_oe);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    bus.ui_in = a; bus.uio_in = 8'h01; tick();
    bus.uio_in = 8'h00; tick();
    bus.ui_in = b; bus.uio_in = 8'h02; tick();
    bus.uio_in = 8'h00; tick();
  endtask

  task automatic pulse_start(input logic bin);
    bus.uio_in = {4'h0, bin, 3'b100};
    tick();
    bus.uio_in = 8'h00;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.uio_out[6] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_run(input string name, input logic bin, input logic [7:0] exp_res,
                        input logic exp_bout);
    int cyc;
    pulse_start(bin);
    check({name, " busy"}, {7'h0, bus.uio_out[7]}, 8'h01);
    wait_done(cyc);
    check({name, " latency"}, 8'(cyc), 8'(LAT));
    check({name, " result"}, bus.uo_out, exp_res);
    check({name, " borrow"}, {7'h0, bus.uio_out[5]}, {7'h0, exp_bout});
    check({name, " idle busy"}, {7'h0, bus.uio_out[7]}, 8'h00);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c, c4, c2;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("reset uo_out", bus.uo_out, 8'h00);
    check("reset uio_out", bus.uio_out, 8'h00);
    check("reset uo_out step4", bus4.uo_out, 8'h00);
`ifdef SUB_OVF_FLAG_EN
    check("reset uio_oe", bus.uio_oe, 8'hF0);
    check("reset uio_oe step4", bus4.uio_oe, 8'hF0);
`else
    check("reset uio_oe", bus.uio_oe, 8'hE0);
    check("reset uio_oe step4", bus4.uio_oe, 8'hE0);
`endif
    rst_n = 1'b1;
    tick();

    load(8'h5A, 8'h3C);
    do_run("basic", 1'b0, 8'h1E, 1'b0);

    load(8'h00, 8'h01);
    do_run("underflow", 1'b0, 8'hFF, 1'b1);

    load(8'h05, 8'h05);
    do_run("equal with borrow", 1'b1, 8'hFF, 1'b1);

    load(8'h80, 8'h01);
    do_run("signed wrap", 1'b0, 8'h7F, 1'b0);
`ifdef SUB_OVF_FLAG_EN
    check("signed wrap ovf", {7'h0, bus.uio_out[4]}, 8'h01);
`endif

    // Borrow-in chain, observed on both STEP=1 and STEP=4 instances.
    load(8'h10, 8'h0F);
    pulse_start(1'b1);
    c = 0; c4 = 0;
    while (bus.uio_out[6] !== 1'b1 && c < 40) begin
      tick();
      c++;
      if (c4 == 0 && bus4.uio_out[6] === 1'b1) c4 = c;
    end
    check("chain latency", 8'(c), 8'd8);
    check("chain latency step4", 8'(c4), 8'd2);
    check("chain result", bus.uo_out, 8'h00);
    check("chain result step4", bus4.uo_out, 8'h00);
    check("chain borrow", {7'h0, bus.uio_out[5]}, 8'h00);

    // Start in the first DONE cycle.
    do_run("back to back", 1'b0, 8'h01, 1'b0);

    // A held-high ld_a loads only the value present at its rising edge.
    bus.ui_in = 8'h22; bus.uio_in = 8'h01; tick();
    bus.ui_in = 8'h99; tick(); tick();
    bus.uio_in = 8'h00; tick();
    do_run("held strobe", 1'b0, 8'h13, 1'b0);

    // Strobes during RUN are ignored.
    load(8'h40, 8'h11);
    pulse_start(1'b0);
    tick(); tick();
    bus.ui_in = 8'hFF; bus.uio_in = 8'h05; tick();
    bus.uio_in = 8'h00;
    wait_done(c2);
    check("ignored latency", 8'(c2 + 3), 8'd8);
    check("ignored result", bus.uo_out, 8'h2F);
    bus.ui_in = 8'h01; bus.uio_in = 8'h02; tick();
    bus.uio_in = 8'h00; tick();
    do_run("A kept", 1'b0, 8'h3F, 1'b0);

    // Reset mid-run.
    pulse_start(1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrun reset uo_out", bus.uo_out, 8'h00);
    check("midrun reset uio_out", bus.uio_out, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    load(8'h03, 8'h01);
    do_run("after reset", 1'b0, 8'h02, 1'b0);

    // Three disabled cycles stretch latency by three.
    load(8'hC8, 8'h64);
    pulse_start(1'b0);
    c = 0;
    repeat (3) begin tick(); c++; end
    ena = 1'b0;
    repeat (3) begin tick(); c++; end
    ena = 1'b1;
    wait_done(c2);
    check("stall latency", 8'(c + c2), 8'd11);
    check("stall result", bus.uo_out, 8'h64);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_subtractor.md
# tt_um_serial_subtractor

- Multi-cycle borrow-chained subtractor; the inverse of the team's combinational full-adder tile.
- Two 8-bit operands and a borrow-in are loaded over the shared `ui_in` bus using strobes on `uio_in`.
- It computes A − B − borrow_in a few bits per clock, then presents the difference on `uo_out` and the status flags on `uio_out`.
- It is a standalone Tiny Tapeout user tile using the standard tile pinout.

## Interface

Parameters:
- `STEP`, default 1: bits processed per clock. Legal values are 1, 2, 4 and 8. Latency is 8/STEP cycles.

Ports:
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: clock enable. When low, all state holds.
- `ui_in`  in  8: operand data bus.
- `uio_in`  in  8: control inputs.
  - [0] `ld_a`
  - [1] `ld_b`
  - [2] `start`
  - [3] `borrow_in`
  - [7:4] unused
- `uo_out`  out  8: result register (difference).
- `uio_out`  out  8: status outputs.
  - [7] `busy`
  - [6] `done`
  - [5] `borrow_out`
  - [4] `ovf` (only when `SUB_OVF_FLAG_EN` is defined)
  - all other bits are 0
- `uio_oe`  out  8: constant 8'b1110_0000, or 8'b1111_0000 with `SUB_OVF_FLAG_EN`.

## Operation

Strobe detection:
- `ld_a`, `ld_b` and `start` are edge-triggered.
- Each is registered every enabled cycle. An action fires when the current sample is 1 and the previous registered sample is 0.

FSM has three states: IDLE, RUN, DONE.
- **IDLE or DONE:**
  - `ld_a` edge: A_reg ← `ui_in`.
  - `ld_b` edge: B_reg ← `ui_in`.
  - Both edges in the same cycle: both registers load the same value.
  - `start` edge:
    - Copy A_reg and B_reg into the working shift registers.
    - Load the borrow register with `borrow_in`.
    - Clear the step counter and `done`.
    - Go to RUN.
  - `start` has priority. Load edges in the same cycle as a `start` edge are ignored; the operation uses the previously loaded values.
- **RUN:**
  - Each enabled cycle:
    - Take the low STEP bits of the working A and B.
    - Compute an STEP-bit difference with the borrow register as borrow-in.
    - Update the borrow register with the borrow out.
    - Shift the difference into the top of the working result.
    - Shift the working A and B right by STEP.
  - All `ld_a`, `ld_b` and `start` edges are ignored. The edge registers still track their inputs.
  - When the step counter reaches 8/STEP − 1:
    - Copy the working result to `uo_out`.
    - Copy the borrow register to `borrow_out`.
    - Set `done` and go to DONE.
- **DONE:**
  - Outputs hold until the next `start` edge.
  - Loads are allowed and do not clear `done`.

Arithmetic and status:
- Unsigned modulo 256.
- `borrow_out` = 1 exactly when A < B + `borrow_in`.
- `busy` = 1 exactly in RUN.
- `done` and `busy` are never both 1.
- `uo_out` holds the previous result throughout RUN and changes only on completion.

## Timing

- Reset: all registers clear to 0 and the FSM returns to IDLE. This means:
  - `uo_out` = 0
  - `busy` = `done` = `borrow_out` = `ovf` = 0
  - A_reg = B_reg = 0
- Reset applied mid-RUN aborts the operation with no partial result. `uo_out` reads 0 after reset.
- `start` edge sampled at enabled edge k:
  - `busy` = 1 after edge k.
  - The result, `done` = 1 and `busy` = 0 are all visible after edge k + 8/STEP.
- Cycles with `ena` = 0 are not counted and do not sample strobes. Latency stretches accordingly.
- A strobe held high across many cycles produces one action. It must return low for at least one enabled cycle to re-arm.
- Back-to-back operation: a `start` edge in the first DONE cycle begins a new run. Minimum issue interval is 8/STEP + 1 cycles, including the strobe low cycle.

## Configuration

- `SUB_OVF_FLAG_EN` defined:
  - `uio_out[4]` = `ovf`, the two's-complement overflow of A − B − `borrow_in`.
  - `ovf` = (A[7] ≠ B[7]) & (D[7] ≠ A[7]), where D is the 8-bit difference.
  - `ovf` is registered at completion alongside `borrow_out`.
  - `uio_oe[4]` = 1.
- `SUB_OVF_FLAG_EN` undefined:
  - No `ovf` logic is built.
  - `uio_out[4]` = 0 and `uio_oe[4]` = 0.

## Test plan

- **Basic subtract:** STEP=1, load A=0x5A, B=0x3C, `borrow_in`=0, pulse `start` → `busy` high 8 cycles, then `uo_out`=0x1E, `borrow_out`=0, `done`=1.
- **Underflow:** A=0x00, B=0x01, `borrow_in`=0 → `uo_out`=0xFF, `borrow_out`=1. With `SUB_OVF_FLAG_EN`: A=0x80, B=0x01 → `uo_out`=0x7F, `ovf`=1, `borrow_out`=0.
- **Borrow-in chain:** A=0x10, B=0x0F, `borrow_in`=1 → `uo_out`=0x00, `borrow_out`=0. Same operands with STEP=4 → `done` after exactly 2 cycles.
- **Ignored strobes while running:** pulse `start` at cycle 3 of RUN and `ld_a` with 0xFF → run completes at the original time with the original result; A_reg is unchanged afterwards.
- **Reset mid-run:** assert `rst_n`=0 at cycle 4 of RUN → all outputs 0 immediately. After release, a new `start` with A=0x03, B=0x01 gives `uo_out`=0x02.
- **ena stall:** drop `ena` for 3 cycles mid-run → completion is delayed by exactly 3 cycles and the result is correct.
